// File: rtl/sram_pkg.sv
// Shared state encoding and default geometry for the asynchronous SRAM controller.
package sram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 20;
  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam int unsigned DEF_LEN_WIDTH   = 4;

  // Wide enough for the largest legal WAIT_CYCLES (15)
  localparam int unsigned WAIT_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Burst controller for an asynchronous SRAM: SETUP / ACCESS / HOLD per beat,
// incrementing (wrapping) address, single tristate data bus.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic                  i_req,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_wready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_addr,
  inout  wire  [DATA_WIDTH-1:0] io_data,
  output logic                  o_n_ce,
  output logic                  o_n_oe,
  output logic                  o_n_we
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(WAIT_CYCLES - 1);

  state_t                    state_q, state_d;
  logic                      wr_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [LEN_WIDTH-1:0]      beat_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      done_q;

  logic accept;
  logic access_end;
  logic bus_oe;
  logic last_beat;

  assign last_beat = (beat_q == '0);

  // State register
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state and strobe decode; strobes follow the state register so reset acts at once
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    access_end = 1'b0;
    bus_oe     = wr_q;
    o_wready   = 1'b0;
    o_busy     = 1'b1;
    o_rvalid   = 1'b0;
    o_n_ce     = 1'b0;
    o_n_oe     = 1'b1;
    o_n_we     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        o_n_ce = 1'b1;
        bus_oe = 1'b0;
        if (i_req) begin
          accept   = 1'b1;
          o_wready = i_write;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        o_n_oe = wr_q;
        o_n_we = !wr_q;
        if (wait_q == WAIT_LAST) begin
          access_end = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        o_rvalid = !wr_q;
        o_wready = wr_q && !last_beat;
        state_d  = last_beat ? ST_IDLE : ST_SETUP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst datapath: latched request, counters, beat data and read capture
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == ST_HOLD) && last_beat;
      if (o_wready) wdata_q <= i_wdata;
      if (accept) begin
        wr_q   <= i_write;
        addr_q <= i_addr;
        beat_q <= i_len;
      end
      if (state_q == ST_ACCESS) wait_q <= access_end ? '0 : wait_q + WAIT_CNT_WIDTH'(1);
      if (access_end && !wr_q) rdata_q <= io_data;
      if ((state_q == ST_HOLD) && !last_beat) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        beat_q <= beat_q - LEN_WIDTH'(1);
      end
    end
  end

  assign io_data = bus_oe ? wdata_q : {DATA_WIDTH{1'bz}};

  assign o_addr  = addr_q;
  assign o_rdata = rdata_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: pin-level SRAM models, array reference memory,
// randomized bursts plus directed wrap, reset-abort and WAIT_CYCLES=1 cases.
module tb_sram_ctrl;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;
  localparam int unsigned WC = 2;
  localparam int unsigned LW = 4;
  localparam int unsigned BW = 8;  // address width of the WAIT_CYCLES=1 instance
  localparam int unsigned BEAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_reset;
  logic          req, write;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic [DW-1:0] wdata;
  logic          wready, rvalid, busy, done, n_ce, n_oe, n_we;
  logic [DW-1:0] rdata;
  logic [AW-1:0] s_addr;
  wire  [DW-1:0] data_bus;

  sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WC), .LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_n_reset(n_reset), .i_req(req), .i_write(write), .i_addr(addr),
    .i_len(len), .i_wdata(wdata), .o_wready(wready), .o_rdata(rdata), .o_rvalid(rvalid),
    .o_busy(busy), .o_done(done), .o_addr(s_addr), .io_data(data_bus),
    .o_n_ce(n_ce), .o_n_oe(n_oe), .o_n_we(n_we)
  );

  logic          b_req;
  logic [BW-1:0] b_addr;
  logic [LW-1:0] b_len;
  logic          b_wready, b_rvalid, b_busy, b_done, b_n_ce, b_n_oe, b_n_we;
  logic [DW-1:0] b_rdata;
  logic [BW-1:0] b_s_addr;
  wire  [DW-1:0] b_bus;

  sram_ctrl #(.ADDR_WIDTH(BW), .DATA_WIDTH(DW), .WAIT_CYCLES(1), .LEN_WIDTH(LW)) dut_b (
    .i_clk(clk), .i_n_reset(n_reset), .i_req(b_req), .i_write(1'b0), .i_addr(b_addr),
    .i_len(b_len), .i_wdata(8'h00), .o_wready(b_wready), .o_rdata(b_rdata), .o_rvalid(b_rvalid),
    .o_busy(b_busy), .o_done(b_done), .o_addr(b_s_addr), .io_data(b_bus),
    .o_n_ce(b_n_ce), .o_n_oe(b_n_oe), .o_n_we(b_n_we)
  );

  // Pin-level SRAM models: drive when selected and output-enabled, store on rising WE
  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] b_sram  [0:(1<<BW)-1];

  assign data_bus = (!n_ce && !n_oe) ? sram[s_addr] : {DW{1'bz}};
  assign b_bus    = (!b_n_ce && !b_n_oe) ? b_sram[b_s_addr] : {DW{1'bz}};

  always @(posedge n_we) begin
    if (n_reset && !n_ce) sram[s_addr] = data_bus;
  end

  function automatic logic [DW-1:0] init_val(input int unsigned a);
    return DW'((a * 37) ^ (a >> 8) ^ 32'h5A);
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [DW-1:0] exp_q [$];
  int exp_done  = 0;
  int seen_done = 0;

  // Monitor: pop expected read data on every rvalid, count done pulses, watch strobes
  always @(negedge clk) begin
    if (n_reset) begin
      if (rvalid) begin
        if (exp_q.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 32'd0);
        else                   chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      end
      if (done) seen_done++;
      chk("strobe_overlap", 32'(n_oe | n_we), 32'd1);
    end
  end

  logic [DW-1:0] bdata [16];

  task automatic run_burst(input bit wr, input logic [AW-1:0] a, input int unsigned n,
                           output int busy_cyc, output int wr_pulses,
                           output int oe_low, output int we_low);
    bit got;
    @(negedge clk);
    req = 1'b1; write = wr; addr = a; len = LW'(n); wdata = bdata[0];
    for (int unsigned i = 0; i <= n; i++) begin
      if (wr) ref_mem[AW'(a + AW'(i))] = bdata[i];
      else    exp_q.push_back(ref_mem[AW'(a + AW'(i))]);
    end
    exp_done++;
    #1;
    wr_pulses = wready ? 1 : 0;
    busy_cyc = 0; oe_low = 0; we_low = 0; got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (busy) begin
        req = 1'($urandom); write = 1'($urandom); addr = AW'($urandom);
      end else begin
        req = 1'b0;
      end
      wdata = bdata[(wr_pulses > int'(n)) ? n : unsigned'(wr_pulses)];
      #1;
      if (busy)   busy_cyc++;
      if (!n_oe)  oe_low++;
      if (!n_we)  we_low++;
      if (wready) wr_pulses++;
      if (done) begin got = 1'b1; break; end
    end
    req = 1'b0;
    if (!got) chk("burst_timeout", 32'd0, 32'd1);
  endtask

  task automatic burst_chk(input string tag, input bit wr, input logic [AW-1:0] a, input int unsigned n);
    int bc, wp, ol, wl;
    run_burst(wr, a, n, bc, wp, ol, wl);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'((n + 1) * (WC + 2)));
    chk({tag, "_wready"},      32'(wp), wr ? 32'(n + 1) : 32'd0);
    chk({tag, "_oe_low"},      32'(ol), wr ? 32'd0 : 32'((n + 1) * WC));
    chk({tag, "_we_low"},      32'(wl), wr ? 32'((n + 1) * WC) : 32'd0);
  endtask

  initial begin
    bit got;
    int done_before;
    logic [AW-1:0] a;
    int unsigned n;
    n_reset = 1'b0;
    req = 1'b0; write = 1'b0; addr = '0; len = '0; wdata = '0;
    b_req = 1'b0; b_addr = '0; b_len = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = init_val(i); ref_mem[i] = init_val(i);
    end
    for (int i = 0; i < (1 << BW); i++) b_sram[i] = init_val(i);
    for (int i = 0; i < 16; i++) bdata[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_n_ce", 32'(n_ce), 32'd1);
    chk("rst_n_oe", 32'(n_oe), 32'd1);
    chk("rst_n_we", 32'(n_we), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    n_reset = 1'b1;

    // Single read of a preloaded byte
    sram[20'h00010] = 8'hA5; ref_mem[20'h00010] = 8'hA5;
    burst_chk("single_read", 1'b0, 20'h00010, 0);
    chk("single_read_rdata", 32'(rdata), 32'hA5);

    // Four-beat write across the top of the address space
    bdata[0] = 8'h11; bdata[1] = 8'h22; bdata[2] = 8'h33; bdata[3] = 8'h44;
    burst_chk("wrap_write", 1'b1, 20'hFFFFE, 3);
    chk("wrap_mem_fffffe", 32'(sram[20'hFFFFE]), 32'h11);
    chk("wrap_mem_fffff",  32'(sram[20'hFFFFF]), 32'h22);
    chk("wrap_mem_00000",  32'(sram[20'h00000]), 32'h33);
    chk("wrap_mem_00001",  32'(sram[20'h00001]), 32'h44);
    burst_chk("wrap_readback", 1'b0, 20'hFFFFE, 3);

    // Write then read the same address
    bdata[0] = 8'h5C;
    burst_chk("wr_same", 1'b1, 20'h0ABCD, 0);
    burst_chk("rd_same", 1'b0, 20'h0ABCD, 0);
    chk("rd_same_rdata", 32'(rdata), 32'h5C);

    // Randomized bursts, biased toward the wrap point
    for (int k = 0; k < 12; k++) begin
      a = ($urandom_range(0, 1) == 0) ? AW'(32'hFFFF0 + $urandom_range(0, 15)) : AW'($urandom);
      n = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) bdata[i] = DW'($urandom);
      burst_chk("rand", 1'($urandom), a, n);
    end

    // Reset during the ACCESS phase of a write
    done_before = seen_done;
    @(negedge clk);
    req = 1'b1; write = 1'b1; addr = 20'h00123; len = 4'd2; wdata = 8'h77;
    @(negedge clk);
    req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!n_we) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("abort_reached_access", 32'(got), 32'd1);
    #1 n_reset = 1'b0;
    #1;
    chk("abort_n_we", 32'(n_we), 32'd1);
    chk("abort_n_ce", 32'(n_ce), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(s_addr), 32'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(seen_done), 32'(done_before));
    burst_chk("post_reset_read", 1'b0, 20'h00123, 1);

    // WAIT_CYCLES=1 instance, two-beat read, request held through the first done
    @(negedge clk);
    b_req = 1'b1; b_addr = 8'h40; b_len = 4'd1;
    for (int t = 1; t <= 20; t++) begin
      bit e_rv, e_dn, e_bs;
      int beat_idx;
      @(negedge clk);
      if (t == 8) b_req = 1'b0;
      #1;
      e_rv = 1'b0; e_dn = 1'b0; e_bs = 1'b0; beat_idx = 0;
      for (int k = 0; k < 2; k++) begin
        int acc;
        acc = k * (2 * BEAT_B + 1);
        if (t > acc && t <= acc + 2 * BEAT_B) e_bs = 1'b1;
        if (t == acc + 2 * BEAT_B + 1) e_dn = 1'b1;
        for (int b = 0; b < 2; b++)
          if (t == acc + b * BEAT_B + BEAT_B) begin e_rv = 1'b1; beat_idx = b; end
      end
      chk("w1_rvalid", 32'(b_rvalid), 32'(e_rv));
      chk("w1_done",   32'(b_done),   32'(e_dn));
      chk("w1_busy",   32'(b_busy),   32'(e_bs));
      if (e_rv) chk("w1_rdata", 32'(b_rdata), 32'(init_val(32'h40 + beat_idx)));
    end

    repeat (2) @(negedge clk);
    chk("done_count", 32'(seen_done), 32'(exp_done));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20: external SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: external SRAM data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, legal range 1..15: cycles each strobe stays low per beat.
REQ-004 SHALL have parameter LEN_WIDTH, default 4: burst length field width.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port i_n_reset, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port i_req, input, 1 bit: operation request.
REQ-008 SHALL have port i_write, input, 1 bit: 1 = write, 0 = read; sampled with i_req.
REQ-009 SHALL have port i_addr, input, ADDR_WIDTH bits: burst start address.
REQ-010 SHALL have port i_len, input, LEN_WIDTH bits: number of beats minus 1.
REQ-011 SHALL have port i_wdata, input, DATA_WIDTH bits: write data, sampled when o_wready = 1.
REQ-012 SHALL have port o_wready, output, 1 bit: write-data accept strobe.
REQ-013 SHALL have port o_rdata, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port o_rvalid, output, 1 bit: 1-cycle pulse marking o_rdata valid.
REQ-015 SHALL have port o_busy, output, 1 bit: operation in progress.
REQ-016 SHALL have port o_done, output, 1 bit: 1-cycle pulse at burst completion.
REQ-017 SHALL have port o_addr, output, ADDR_WIDTH bits: address pins.
REQ-018 SHALL have port io_data, inout, DATA_WIDTH bits: data pins.
REQ-019 SHALL have ports o_n_ce, o_n_oe and o_n_we, output, 1 bit each: active-low chip enable, output enable and write enable.

Function
REQ-020 SHALL implement states IDLE, SETUP, ACCESS and HOLD.
REQ-021 SHALL accept a request only in IDLE with i_req = 1; i_write, i_addr and i_len are latched and the next state is SETUP; i_req while busy SHALL be ignored.
REQ-022 SHALL hold o_busy = 1 in SETUP, ACCESS and HOLD, and 0 in IDLE.
REQ-023 SETUP SHALL last 1 cycle: o_addr = current address, o_n_ce = 0, o_n_oe = 1, o_n_we = 1.
REQ-024 ACCESS SHALL last exactly WAIT_CYCLES cycles: o_n_oe = 0 for a read, o_n_we = 0 for a write.
REQ-025 HOLD SHALL last 1 cycle: both strobes high, o_n_ce = 0; one beat therefore takes WAIT_CYCLES+2 cycles.
REQ-026 Read: io_data SHALL be registered into o_rdata on the final ACCESS edge, with o_rvalid = 1 during HOLD only.
REQ-027 Write: io_data SHALL be driven from the beat data register during SETUP, ACCESS and HOLD, and be hi-Z in every other case.
REQ-028 o_wready SHALL be combinational: 1 in IDLE when i_req & i_write, and 1 in HOLD of a non-final write beat; i_wdata is captured on that edge.
REQ-029 After a non-final HOLD, the address SHALL increment by 1 modulo 2^ADDR_WIDTH (wrap from all-ones to 0) and the next state is SETUP.
REQ-030 After the final HOLD, the next state SHALL be IDLE, o_n_ce = 1, and o_done = 1 for exactly that first IDLE cycle.
REQ-031 A burst SHALL comprise i_len+1 beats (1..2^LEN_WIDTH).
REQ-032 o_n_oe and o_n_we SHALL never both be 0; io_data SHALL never be driven while o_n_oe = 0.

Reset
REQ-033 While i_n_reset = 0, the block SHALL immediately (without waiting for a clock edge) force IDLE, o_n_ce = o_n_oe = o_n_we = 1, io_data hi-Z, o_addr = 0, o_rdata = 0, o_rvalid = o_done = o_busy = 0.
REQ-034 Reset mid-burst SHALL abort the burst with no o_done; the first request after reset release SHALL behave normally.

Structure
REQ-035 Package sram_pkg SHALL hold the state encoding constants and the default ADDR_WIDTH, DATA_WIDTH, WAIT_CYCLES and LEN_WIDTH values.
REQ-036 The wait counter and beat counter SHALL be inline; no sub-module is required; the tristate SHALL be a single continuous assignment on io_data.

Verification (WAIT_CYCLES = 2 unless stated)
REQ-037 Single read, i_addr = 0x00010, i_len = 0, model holds 0xA5 -> o_n_oe low 2 cycles, o_rvalid pulse with o_rdata = 0xA5, o_done 4 cycles after accept.
REQ-038 Write burst, i_addr = 0xFFFFE, i_len = 3, data 0x11/0x22/0x33/0x44 -> model addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 hold that data; 4 o_wready pulses; o_busy high 16 cycles.
REQ-039 Back-to-back write then read of the same address -> read returns the written byte, and io_data is never driven while o_n_oe = 0.
REQ-040 i_n_reset pulled low during ACCESS of a write -> o_n_we = 1 and io_data = Z in the same timestep, no o_done; a subsequent read succeeds.
REQ-041 WAIT_CYCLES = 1 build, i_len = 1 read -> each beat 3 cycles, 2 o_rvalid pulses; i_req held high throughout starts exactly one new burst after o_done.
